// File: rtl/divisor_pkg.sv
// divisor_pkg: shared constants and width helpers for the programmable clock divider
package divisor_pkg;

    localparam int CNT_W_DEF        = 17;
    localparam int DEFAULT_HALF_DEF = 50000;
    localparam int MIN_HALF         = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // channel-select width never collapses to zero bits, even for a single channel
    function automatic int ch_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/divisor_chan.sv
// divisor_chan: one divider channel with a shadowed half-period applied only at period end
module divisor_chan
    import divisor_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             clk_o,
    output logic             tick_o,
    output logic             pending_o
);

    localparam logic [CNT_W-1:0] RST_HALF =
        (DEFAULT_HALF < MIN_HALF) ? CNT_W'(MIN_HALF) : CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] cnt_q, cnt_d, half_q, half_d, shadow_q, shadow_d;
    logic             pending_q, pending_d, clk_q, clk_d, tick_q, tick_d;
    logic             boundary, apply;

    // count to half-1, toggle the output there, and hand the shadow over only at a falling edge or while idle
    always_comb begin
        boundary  = en && (cnt_q == half_q - CNT_W'(MIN_HALF));
        apply     = pending_q && (!en || (boundary && clk_q));
        cnt_d     = en ? (boundary ? '0 : cnt_q + CNT_W'(1)) : '0;
        clk_d     = en && (clk_q ^ boundary);
        tick_d    = boundary && !clk_q;
        half_d    = apply ? shadow_q : half_q;
        shadow_d  = wr ? wr_half : shadow_q;
        pending_d = wr || (pending_q && !apply);
    end

    // state register; reset discards any pending shadow
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            half_q    <= RST_HALF;
            shadow_q  <= RST_HALF;
            pending_q <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_o     = clk_q;
    assign tick_o    = tick_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/divisor_prog.sv
// divisor_prog: multi-channel programmable clock divider with a valid/ready config port
module divisor_prog
    import divisor_pkg::*;
#(
    parameter  int N_CH         = 4,
    parameter  int CNT_W        = CNT_W_DEF,
    parameter  int DEFAULT_HALF = DEFAULT_HALF_DEF,
    localparam int CH_W         = ch_width(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
    output logic [N_CH-1:0]  clk_o,
    output logic [N_CH-1:0]  tick_o
);

    localparam int N_PAD = 1 << CH_W;

    logic [N_PAD-1:0] pend;
    logic [CNT_W-1:0] half_sat;
    logic             accept;

    // saturate a zero half-period; out-of-range channels read as never pending so writes to them are swallowed
    always_comb begin
        half_sat  = (cfg_half < CNT_W'(MIN_HALF)) ? CNT_W'(MIN_HALF) : cfg_half;
        cfg_ready = !pend[cfg_ch];
        accept    = cfg_valid && cfg_ready;
    end

    for (genvar c = 0; c < N_PAD; c++) begin : g_ch
        if (c < N_CH) begin : g_live
            divisor_chan #(
                .CNT_W        (CNT_W),
                .DEFAULT_HALF (DEFAULT_HALF)
            ) u_chan (
                .clk       (clk),
                .reset     (reset),
                .en        (en[c]),
                .wr        (accept && (cfg_ch == CH_W'(c))),
                .wr_half   (half_sat),
                .clk_o     (clk_o[c]),
                .tick_o    (tick_o[c]),
                .pending_o (pend[c])
            );
        end else begin : g_pad
            assign pend[c] = 1'b0;
        end
    end

endmodule

// File: tb/tb_divisor_prog.sv
// tb_divisor_prog: directed stimulus with a queued edge scoreboard checked by an independent monitor
module tb_divisor_prog;

    localparam int W  = 8;
    localparam int DH = 5;

    logic         clk = 0, reset = 1;
    logic [3:0]   en = '0;
    logic         cfg_valid = 0;
    logic [1:0]   cfg_ch = '0;
    logic [W-1:0] cfg_half = '0;
    logic         cfg_ready;
    logic [3:0]   clk_o, tick_o;

    logic [2:0]   en3 = '0;
    logic         cv3 = 0;
    logic [1:0]   cc3 = '0;
    logic [W-1:0] ch3 = '0;
    logic         cr3;
    logic [2:0]   co3, to3;

    int   cyc = 0, vectors = 0, miscompares = 0, mon_e;
    bit   mon_on = 0;
    logic [3:0] prev = '0;
    int   exp_rise [4][$];
    int   exp_fall [4][$];

    divisor_prog #(.N_CH(4), .CNT_W(W), .DEFAULT_HALF(DH)) u_dut (
        .clk(clk), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_half(cfg_half), .clk_o(clk_o), .tick_o(tick_o)
    );

    divisor_prog #(.N_CH(3), .CNT_W(W), .DEFAULT_HALF(DH)) u_dut3 (
        .clk(clk), .reset(reset), .en(en3), .cfg_valid(cv3), .cfg_ready(cr3),
        .cfg_ch(cc3), .cfg_half(ch3), .clk_o(co3), .tick_o(to3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
        #1;
    endtask

    task automatic ex(input int ch, input bit rise, input int c);
        if (rise) exp_rise[ch].push_back(c);
        else exp_fall[ch].push_back(c);
    endtask

    task automatic wr(input int ch, input int half);
        cfg_ch = 2'(ch);
        cfg_half = W'(half);
        cfg_valid = 1;
    endtask

    // monitor: every observed edge of clk_o pops the expected cycle for that channel
    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < 4; i++) begin
                if (clk_o[i] && !prev[i]) begin
                    if (exp_rise[i].size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL rise_ch%0d: unexpected rise at cycle %0d", i, cyc);
                    end else begin
                        mon_e = exp_rise[i].pop_front();
                        chk($sformatf("rise_ch%0d", i), cyc, mon_e);
                        chk($sformatf("tick_on_rise_ch%0d", i), int'(tick_o[i]), 1);
                    end
                end else if (!clk_o[i] && prev[i]) begin
                    if (exp_fall[i].size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL fall_ch%0d: unexpected fall at cycle %0d", i, cyc);
                    end else begin
                        mon_e = exp_fall[i].pop_front();
                        chk($sformatf("fall_ch%0d", i), cyc, mon_e);
                        chk($sformatf("tick_on_fall_ch%0d", i), int'(tick_o[i]), 0);
                    end
                end else if (tick_o[i]) begin
                    vectors++; miscompares++;
                    $display("FAIL stray_tick_ch%0d: tick 1 without rise, expected 0 (cycle %0d)", i, cyc);
                end
            end
        end
        prev = clk_o;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        // reset state, then channel 0 at default half 5
        wait_cyc(5);
        chk("reset_clk_o", int'(clk_o), 0);
        chk("reset_tick_o", int'(tick_o), 0);
        chk("reset_ready", int'(cfg_ready), 1);
        mon_on = 1;
        foreach (exp_rise[i]) exp_rise[i].delete();
        ex(0,1,10); ex(0,0,15); ex(0,1,20); ex(0,0,25);
        ex(0,1,28); ex(0,0,31); ex(0,1,34); ex(0,0,37);
        ex(0,1,40); ex(0,0,42); ex(0,1,48); ex(0,0,52); ex(0,1,56); ex(0,0,60);
        reset = 0;
        en[0] = 1;
        // mid-high write of half 3 on channel 0
        wait_cyc(21);
        wr(0, 3); #1;
        chk("t2_ready_before", int'(cfg_ready), 1);
        wait_cyc(22); cfg_valid = 0; #1;
        chk("t2_ready_pending", int'(cfg_ready), 0);
        wait_cyc(24); chk("t2_ready_still", int'(cfg_ready), 0);
        wait_cyc(25); chk("t2_ready_back", int'(cfg_ready), 1);
        // disable mid-high with a write of half 4 applied while idle
        wait_cyc(41);
        en[0] = 0; wr(0, 4);
        wait_cyc(42); cfg_valid = 0; #1;
        chk("t5_ready_pending", int'(cfg_ready), 0);
        wait_cyc(43); chk("t5_ready_applied", int'(cfg_ready), 1);
        wait_cyc(44); en[0] = 1;
        wait_cyc(61); en[0] = 0;
        // channel 2 with half 0 saturated to 1
        wait_cyc(65);
        ex(2,1,68); ex(2,0,69); ex(2,1,70); ex(2,0,71); ex(2,1,72); ex(2,0,73);
        wr(2, 0);
        wait_cyc(66); cfg_valid = 0; #1;
        chk("t3_ready_pending", int'(cfg_ready), 0);
        wait_cyc(67); chk("t3_ready_applied", int'(cfg_ready), 1);
        en[2] = 1;
        wait_cyc(73); en[2] = 0;
        // channel 1: write accepted exactly on the falling boundary
        wait_cyc(77);
        ex(1,1,82); ex(1,0,87); ex(1,1,92); ex(1,0,97);
        ex(1,1,99); ex(1,0,101); ex(1,1,103); ex(1,0,105);
        cfg_ch = 2'd1; en[1] = 1;
        wait_cyc(86);
        wr(1, 2); #1;
        chk("t4_ready_before", int'(cfg_ready), 1);
        wait_cyc(87); cfg_valid = 0; #1;
        chk("t4_ready_pending", int'(cfg_ready), 0);
        wait_cyc(96); chk("t4_ready_still", int'(cfg_ready), 0);
        wait_cyc(97); chk("t4_ready_back", int'(cfg_ready), 1);
        wait_cyc(105); en[1] = 0;
        // channel 3: reset while high with a pending write
        wait_cyc(109);
        ex(3,1,114); ex(3,0,118); ex(3,1,123); ex(3,0,128); ex(3,1,133); ex(3,0,138);
        cfg_ch = 2'd3; en[3] = 1;
        wait_cyc(115); wr(3, 7);
        wait_cyc(116); cfg_valid = 0; #1;
        chk("t6_ready_pending", int'(cfg_ready), 0);
        wait_cyc(117); reset = 1;
        wait_cyc(118);
        chk("t6_reset_clk_o", int'(clk_o), 0);
        chk("t6_reset_tick_o", int'(tick_o), 0);
        chk("t6_reset_ready", int'(cfg_ready), 1);
        reset = 0;
        wait_cyc(139); en[3] = 0;
        // out-of-range channel on a 3-channel instance is accepted and ignored
        wait_cyc(143);
        cc3 = 2'd3; ch3 = W'(9); cv3 = 1; #1;
        chk("oor_ready", int'(cr3), 1);
        wait_cyc(144); cv3 = 0;
        for (int c = 0; c < 4; c++) begin
            cc3 = 2'(c); #1;
            chk($sformatf("oor_ready_ch%0d", c), int'(cr3), 1);
        end
        en3[0] = 1;
        wait_cyc(148); chk("oor_clk_before", int'(co3[0]), 0);
        wait_cyc(149);
        chk("oor_clk_rise", int'(co3[0]), 1);
        chk("oor_tick_rise", int'(to3[0]), 1);
        wait_cyc(150); en3 = '0;
        wait_cyc(152);
        for (int c = 0; c < 4; c++)
            chk($sformatf("leftover_ch%0d", c), exp_rise[c].size() + exp_fall[c].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
